// File: rtl/interrupt_controller_4.sv
// interrupt_controller_4
//   Four-line edge-triggered interrupt controller with a mask register,
//   fixed-priority arbitration (line 3 highest) and a three-state
//   present / acknowledge / end-of-interrupt handshake with the CPU.
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   raw request lines; a rising edge latches the line pending
//   mask_we    in   load mask from mask_in this cycle
//   mask_in    in   new mask value (1 = line masked)
//   ack        in   CPU accepts the presented interrupt (used in PRESENT only)
//   eoi        in   CPU finished servicing (used in WAIT_EOI only)
//   irq        out  interrupt presented to the CPU
//   id[1:0]    out  index of the presented or in-service line
//   pending    out  latched pending bits, independent of mask
//   mask       out  current mask register
//   in_service out  high while waiting for eoi
//   lost_cnt   out  saturating count of cycles in which an edge hit a
//                   line that was already pending
//
// Handshake: irq is a level held from entry into PRESENT until the cycle
// after ack is sampled; ack is only honoured while irq is high, and eoi is
// only honoured while in_service is high. Both outputs come straight from
// the state register.
module interrupt_controller_4 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       mask_we,
   input  logic [3:0] mask_in,
   input  logic       ack,
   input  logic       eoi,
   output logic       irq,
   output logic [1:0] id,
   output logic [3:0] pending,
   output logic [3:0] mask,
   output logic       in_service,
   output logic [3:0] lost_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESENT  = 2'd1,
      WAIT_EOI = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] req_q;
   logic [3:0] rise;
   logic [3:0] eligible;
   logic [3:0] clr_vec;
   logic [3:0] pending_nxt;
   logic [1:0] winner;
   logic [1:0] id_nxt;
   logic       ack_take;
   logic       lost_hit;

   assign rise     = req & ~req_q;
   assign eligible = pending & ~mask;
   assign ack_take = (state == PRESENT) && ack;

   // Clear of the acknowledged line; a fresh edge on that same line in the
   // same cycle overrides the clear, and is not counted as lost because the
   // old event is being consumed at that moment.
   assign clr_vec     = ack_take ? (4'b0001 << id) : 4'b0000;
   assign pending_nxt = (pending & ~clr_vec) | rise;
   assign lost_hit    = |(rise & pending & ~clr_vec);

   // Fixed priority: highest set eligible bit wins.
   always_comb begin
      winner = 2'd0;
      if (eligible[3])      winner = 2'd3;
      else if (eligible[2]) winner = 2'd2;
      else if (eligible[1]) winner = 2'd1;
      else                  winner = 2'd0;
   end

   always_comb begin
      state_nxt = state;
      id_nxt    = id;
      case (state)
         IDLE: begin
            if (|eligible) begin
               id_nxt    = winner;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            // id is frozen here: no preemption and no effect from masking.
            if (ack) state_nxt = WAIT_EOI;
         end
         WAIT_EOI: begin
            if (eoi) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign irq        = (state == PRESENT);
   assign in_service = (state == WAIT_EOI);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         id       <= 2'd0;
         pending  <= 4'b0000;
         mask     <= 4'b0000;
         lost_cnt <= 4'd0;
         // Loading the live request value means a line held high across
         // reset does not look like a new edge afterwards.
         req_q    <= req;
      end else begin
         state   <= state_nxt;
         id      <= id_nxt;
         pending <= pending_nxt;
         req_q   <= req;
         if (mask_we) mask <= mask_in;
         if (lost_hit && (lost_cnt != 4'd15)) lost_cnt <= lost_cnt + 4'd1;
      end
   end

endmodule
